// File: rtl/wash_pkg.sv
// Shared types and defaults for the wash-cycle sequencer: phase encodings,
// default phase durations and the actuator bundle.
package wash_pkg;

  typedef enum logic [2:0] {
    PhIdle  = 3'd0,
    PhFill  = 3'd1,
    PhWash  = 3'd2,
    PhRinse = 3'd3,
    PhSpin  = 3'd4,
    PhDrain = 3'd5,
    PhDone  = 3'd6
  } phase_e;

  localparam logic [15:0] DefClkFreq = 16'd50;
  localparam logic [15:0] DefFillS   = 16'd2;
  localparam logic [15:0] DefWashS   = 16'd5;
  localparam logic [15:0] DefRinseS  = 16'd3;
  localparam logic [15:0] DefSpinS   = 16'd4;
  localparam logic [15:0] DefDrainS  = 16'd2;

  typedef struct packed {
    logic water_valve;
    logic motor_on;
    logic spin_fast;
    logic drain_pump;
  } act_t;

  // Phases that the lid switch is allowed to freeze.
  function automatic logic is_pausable(phase_e p);
    return p inside {PhFill, PhWash, PhRinse, PhSpin};
  endfunction

  function automatic logic is_timed(phase_e p);
    return is_pausable(p) || (p == PhDrain);
  endfunction

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// Sequencer-to-timer link: the sequencer programs, clears and enables the
// timer and consumes its sticky done level.
interface wash_cycle_sequencer_if;
  logic        timer_en;
  logic        timer_clr;
  logic [15:0] timer_clk_freq;
  logic [15:0] timer_period;
  logic        timer_done;

  modport master (
    output timer_en, timer_clr, timer_clk_freq, timer_period,
    input  timer_done
  );

  modport slave (
    input  timer_en, timer_clr, timer_clk_freq, timer_period,
    output timer_done
  );
endinterface

// File: rtl/wash_phase_rom.sv
// Combinational lookup from phase to timer period and unpaused actuator set.
module wash_phase_rom
  import wash_pkg::*;
#(
  parameter logic [15:0] FILL_S  = DefFillS,
  parameter logic [15:0] WASH_S  = DefWashS,
  parameter logic [15:0] RINSE_S = DefRinseS,
  parameter logic [15:0] SPIN_S  = DefSpinS,
  parameter logic [15:0] DRAIN_S = DefDrainS
) (
  input  phase_e      phase,
  output logic [15:0] period,
  output act_t        act
);

  always_comb begin
    period = '0;
    act    = '0;
    case (phase)
      PhFill: begin
        period          = FILL_S;
        act.water_valve = 1'b1;
      end
      PhWash: begin
        period       = WASH_S;
        act.motor_on = 1'b1;
      end
      PhRinse: begin
        period       = RINSE_S;
        act.motor_on = 1'b1;
      end
      PhSpin: begin
        period         = SPIN_S;
        act.motor_on   = 1'b1;
        act.spin_fast  = 1'b1;
        act.drain_pump = 1'b1;
      end
      PhDrain: begin
        period         = DRAIN_S;
        act.drain_pump = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine phase controller: steps FILL/WASH/RINSE/SPIN (or DRAIN on
// abort) by driving an external timer, with lid pause and optional double wash.
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter logic [15:0] CLK_FREQ = DefClkFreq,
  parameter logic [15:0] FILL_S   = DefFillS,
  parameter logic [15:0] WASH_S   = DefWashS,
  parameter logic [15:0] RINSE_S  = DefRinseS,
  parameter logic [15:0] SPIN_S   = DefSpinS,
  parameter logic [15:0] DRAIN_S  = DefDrainS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          lid_open,
  input  logic                          double_wash,
  wash_cycle_sequencer_if.master        tmr,
  output logic [2:0]                    phase,
  output logic                          busy,
  output logic                          water_valve,
  output logic                          motor_on,
  output logic                          spin_fast,
  output logic                          drain_pump,
  output logic                          cycle_done
);

  phase_e      state_q, state_d;
  logic        clr_q, clr_d;
  logic        dw_q, dw_d;
  logic        paused_q;
  logic        pause_act;
  logic        advance;
  logic [15:0] rom_period;
  act_t        rom_act;

  // Lid is registered so no output has a combinational path from an input.
  assign pause_act = paused_q && is_pausable(state_q);
  assign advance   = tmr.timer_done && !clr_q && !pause_act;

  always_comb begin
    state_d = state_q;
    dw_d    = dw_q;
    case (state_q)
      PhIdle: begin
        if (start && !lid_open) begin
          state_d = PhFill;
          dw_d    = double_wash;
        end
      end
      PhFill: begin
        if (abort)        state_d = PhDrain;
        else if (advance) state_d = PhWash;
      end
      PhWash: begin
        if (abort)        state_d = PhDrain;
        else if (advance) state_d = PhRinse;
      end
      PhRinse: begin
        if (abort) begin
          state_d = PhDrain;
        end else if (advance) begin
          if (dw_q) begin
            state_d = PhWash;
            dw_d    = 1'b0;
          end else begin
            state_d = PhSpin;
          end
        end
      end
      PhSpin: begin
        if (abort)        state_d = PhDrain;
        else if (advance) state_d = PhDone;
      end
      PhDrain: begin
        if (advance) state_d = PhDone;
      end
      PhDone:  state_d = PhIdle;
      default: state_d = PhIdle;
    endcase
    clr_d = (state_d != state_q) && is_timed(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= PhIdle;
      clr_q    <= 1'b0;
      dw_q     <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      dw_q     <= dw_d;
      paused_q <= lid_open;
    end
  end

  wash_phase_rom #(
    .FILL_S  (FILL_S),
    .WASH_S  (WASH_S),
    .RINSE_S (RINSE_S),
    .SPIN_S  (SPIN_S),
    .DRAIN_S (DRAIN_S)
  ) u_rom (
    .phase  (state_q),
    .period (rom_period),
    .act    (rom_act)
  );

  always_comb begin
    tmr.timer_en       = is_timed(state_q) && !pause_act;
    tmr.timer_clr      = clr_q;
    tmr.timer_clk_freq = CLK_FREQ;
    tmr.timer_period   = rom_period;
    phase              = state_q;
    busy               = (state_q != PhIdle);
    cycle_done         = (state_q == PhDone);
    water_valve        = rom_act.water_valve && !pause_act;
    motor_on           = rom_act.motor_on    && !pause_act;
    spin_fast          = rom_act.spin_fast   && !pause_act;
    drain_pump         = rom_act.drain_pump  && !pause_act;
  end

endmodule
